// File: rtl/mem_bus_pkg.sv
// Shared types for the memory-bus initiator: request opcodes, FSM states and
// the registered strobe bundle, plus the state-to-strobe decode.
package mem_bus_pkg;

  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    OP_MEM_RD   = 2'd0,
    OP_MEM_WR   = 2'd1,
    OP_BANK_SET = 2'd2,
    OP_BANK_GET = 2'd3
  } op_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MAR,
    ST_WR,
    ST_RD,
    ST_BSET_ADDR,
    ST_BSET,
    ST_BGET,
    ST_RESP,
    ST_TURN
  } state_t;

  typedef struct packed {
    logic set_mar;
    logic read_m;
    logic write_m;
    logic read_r;
    logic write_r;
    logic bus_en;
  } strobe_t;

  // Bus drive is enabled only alongside set_mar and write_m.
  function automatic strobe_t strobes_for(input state_t st);
    strobe_t s;
    s = '0;
    case (st)
      ST_MAR, ST_BSET_ADDR: begin s.set_mar = 1'b1; s.bus_en = 1'b1; end
      ST_WR:                begin s.write_m = 1'b1; s.bus_en = 1'b1; end
      ST_RD:                s.read_m  = 1'b1;
      ST_BSET:              s.write_r = 1'b1;
      ST_BGET:              s.read_r  = 1'b1;
      default:              s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_bus_initiator.sv
// Strobe-bus master for the MemoryController: turns valid/ready requests into
// registered set_mar/read/write strobe sequences. MEM_BUS_MAR_CACHE_EN skips redundant MAR loads.
module mem_bus_initiator
  import mem_bus_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              programming_mode,
  input  logic              req_valid,
  output logic              req_ready,
  input  op_t               req_op,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              set_mar,
  output logic              read_m,
  output logic              write_m,
  output logic              read_r,
  output logic              write_r,
  inout  wire  [DATA_W-1:0] data_bus
);

  localparam int               CNT_W    = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_t               op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] bus_q, bus_d;
  strobe_t           strb_q, strb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              live_q;
  logic              accept, abort, last_rd, mar_hit;

  assign req_ready = live_q && (state_q == ST_IDLE) && !programming_mode;
  assign accept    = req_valid && req_ready;
  assign abort     = programming_mode && (state_q != ST_IDLE);
  assign last_rd   = ((state_q == ST_RD) || (state_q == ST_BGET)) && (cnt_q == CNT_ONE);

`ifdef MEM_BUS_MAR_CACHE_EN
  logic [DATA_W-1:0] last_mar_q;
  logic              mar_valid_q;

  assign mar_hit = mar_valid_q && (req_addr == last_mar_q) &&
                   ((req_op == OP_MEM_RD) || (req_op == OP_MEM_WR));

  // set_mar is only ever issued straight out of an accept, so req_addr is the MAR value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_mar_q  <= '0;
      mar_valid_q <= 1'b0;
    end else if (programming_mode) begin
      mar_valid_q <= 1'b0;
    end else if (strb_d.set_mar) begin
      last_mar_q  <= req_addr;
      mar_valid_q <= 1'b1;
    end
  end
`else
  assign mar_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_MEM_RD;
      wdata_q     <= '0;
      bus_q       <= '0;
      strb_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      live_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      bus_q       <= bus_d;
      strb_q      <= strb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      live_q      <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = accept ? req_op : op_q;
    wdata_d = accept ? req_wdata : wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (req_op)
            OP_MEM_WR:   state_d = mar_hit ? ST_WR : ST_MAR;
            OP_MEM_RD:   begin
              state_d = mar_hit ? ST_RD : ST_MAR;
              cnt_d   = LAT_LOAD;
            end
            OP_BANK_SET: state_d = ST_BSET_ADDR;
            OP_BANK_GET: begin
              state_d = ST_BGET;
              cnt_d   = LAT_LOAD;
            end
            default:     state_d = ST_IDLE;
          endcase
        end
      end
      ST_MAR: begin
        state_d = (op_q == OP_MEM_WR) ? ST_WR : ST_RD;
        cnt_d   = LAT_LOAD;
      end
      ST_WR, ST_BSET: state_d = ST_RESP;
      ST_BSET_ADDR:   state_d = ST_BSET;
      ST_RD, ST_BGET: begin
        if (last_rd) state_d = ST_RESP;
        else         cnt_d   = cnt_q - CNT_ONE;
      end
      ST_RESP: state_d = ((op_q == OP_MEM_RD) || (op_q == OP_BANK_GET)) ? ST_TURN : ST_IDLE;
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Outputs are decoded from the next state and registered, so strobes and bus drive move together.
  always_comb begin
    strb_d      = strobes_for(state_d);
    rsp_valid_d = (state_d == ST_RESP);
    rsp_data_d  = (last_rd && !abort) ? data_bus : rsp_data_q;
    bus_d       = bus_q;
    if ((state_d == ST_MAR) || (state_d == ST_BSET_ADDR)) bus_d = req_addr;
    else if (state_d == ST_WR)                            bus_d = wdata_d;
  end

  assign set_mar   = strb_q.set_mar;
  assign read_m    = strb_q.read_m;
  assign write_m   = strb_q.write_m;
  assign read_r    = strb_q.read_r;
  assign write_r   = strb_q.write_r;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign data_bus  = strb_q.bus_en ? bus_q : 'z;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Randomized bench for mem_bus_initiator: a per-operation cycle plan built from
// the op rules drives a memory/bank model on the bus and predicts every cycle.
module tb_mem_bus_initiator;
  import mem_bus_pkg::*;

  localparam int W        = 16;
  localparam int READ_LAT = 2;
  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_MAR  = 5'b10000;
  localparam logic [4:0] S_RDM  = 5'b01000;
  localparam logic [4:0] S_WRM  = 5'b00100;
  localparam logic [4:0] S_RDR  = 5'b00010;
  localparam logic [4:0] S_WRR  = 5'b00001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         programming_mode;
  logic         req_valid;
  logic         req_ready;
  op_t          req_op;
  logic [W-1:0] req_addr, req_wdata;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         set_mar, read_m, write_m, read_r, write_r;
  wire  [W-1:0] data_bus;
  logic         tb_drv;
  logic [W-1:0] tb_val;
  logic [4:0]   strb_obs;

  assign data_bus = tb_drv ? tb_val : 'z;
  assign strb_obs = {set_mar, read_m, write_m, read_r, write_r};

  mem_bus_initiator #(.DATA_W(W), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .reset(rst_n), .programming_mode(programming_mode),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .set_mar(set_mar), .read_m(read_m), .write_m(write_m),
    .read_r(read_r), .write_r(write_r), .data_bus(data_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: memory contents, bank register, response register, MAR cache.
  logic [W-1:0] mem [0:255];
  logic [W-1:0] bank_m, rsp_m, last_mar_m;
  logic         mar_valid_m;

  typedef struct {
    logic [4:0]   strb;
    logic         dut_drv;
    logic [W-1:0] bus;
    logic         rsp_v;
    logic [W-1:0] rsp_d;
  } cyc_t;
  cyc_t plan[$];

  function automatic void push(input logic [4:0] s, input logic d, input logic [W-1:0] b,
                               input logic v);
    cyc_t c;
    c.strb = s; c.dut_drv = d; c.bus = b; c.rsp_v = v; c.rsp_d = rsp_m;
    plan.push_back(c);
  endfunction

  function automatic void plan_op(input op_t op, input logic [W-1:0] a, input logic [W-1:0] wd);
    logic hit;
    logic [7:0] ix;
    hit = 1'b0;
    ix  = a[7:0];
`ifdef MEM_BUS_MAR_CACHE_EN
    hit = mar_valid_m && (last_mar_m == a) && ((op == OP_MEM_RD) || (op == OP_MEM_WR));
`endif
    plan.delete();
    case (op)
      OP_MEM_WR: begin
        if (!hit) push(S_MAR, 1'b1, a, 1'b0);
        push(S_WRM, 1'b1, wd, 1'b0);
        mem[ix] = wd;
        push(S_NONE, 1'b0, '0, 1'b1);
      end
      OP_MEM_RD: begin
        if (!hit) push(S_MAR, 1'b1, a, 1'b0);
        for (int i = 0; i < READ_LAT; i++)
          push(S_RDM, 1'b0, (i == READ_LAT - 1) ? mem[ix] : ~mem[ix], 1'b0);
        rsp_m = mem[ix];
        push(S_NONE, 1'b0, '0, 1'b1);
        push(S_NONE, 1'b0, '0, 1'b0);
      end
      OP_BANK_SET: begin
        push(S_MAR, 1'b1, a, 1'b0);
        push(S_WRR, 1'b0, '0, 1'b0);
        bank_m = a;
        push(S_NONE, 1'b0, '0, 1'b1);
      end
      default: begin
        for (int i = 0; i < READ_LAT; i++)
          push(S_RDR, 1'b0, (i == READ_LAT - 1) ? bank_m : ~bank_m, 1'b0);
        rsp_m = bank_m;
        push(S_NONE, 1'b0, '0, 1'b1);
        push(S_NONE, 1'b0, '0, 1'b0);
      end
    endcase
    if (op == OP_BANK_SET || ((op == OP_MEM_RD || op == OP_MEM_WR) && !hit)) begin
      last_mar_m  = a;
      mar_valid_m = 1'b1;
    end
  endfunction

  // Issues one request, then checks every cycle of the predicted plan while
  // junk requests are held on the port to prove nothing else is accepted.
  task automatic run_op(input op_t op, input logic [W-1:0] a, input logic [W-1:0] wd);
    @(posedge clk); #1;
    programming_mode = 1'b0;
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    tb_drv = 1'b1; tb_val = '0;
    @(negedge clk);
    check("accept_ready", req_ready, 1'b1);
    check("accept_strb", strb_obs, S_NONE);
    check("accept_rsp_data", rsp_data, rsp_m);
    plan_op(op, a, wd);
    foreach (plan[i]) begin
      @(posedge clk); #1;
      req_op = op_t'($urandom_range(0, 3));
      req_addr = W'($urandom); req_wdata = W'($urandom);
      tb_drv = !plan[i].dut_drv;
      tb_val = plan[i].dut_drv ? '0 : plan[i].bus;
      @(negedge clk);
      check($sformatf("op%0d_c%0d_strb", op, i), strb_obs, plan[i].strb);
      check($sformatf("op%0d_c%0d_bus", op, i), data_bus, plan[i].bus);
      check($sformatf("op%0d_c%0d_rsp_valid", op, i), rsp_valid, plan[i].rsp_v);
      check($sformatf("op%0d_c%0d_rsp_data", op, i), rsp_data, plan[i].rsp_d);
      check($sformatf("op%0d_c%0d_ready", op, i), req_ready, 1'b0);
    end
  endtask

  // One idle cycle; with pm set, a request is presented and must be refused.
  task automatic idle_cycle(input logic pm);
    @(posedge clk); #1;
    programming_mode = pm;
    req_valid = pm; req_op = OP_MEM_WR; req_addr = 16'h0001;
    tb_drv = 1'b1; tb_val = '0;
    if (pm) mar_valid_m = 1'b0;
    @(negedge clk);
    check("idle_ready", req_ready, !pm);
    check("idle_strb", strb_obs, S_NONE);
    check("idle_bus", data_bus, 16'h0000);
    check("idle_rsp_valid", rsp_valid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strb"}, strb_obs, S_NONE);
    check({tag, "_bus"}, data_bus, 16'h0000);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_data"}, rsp_data, 16'h0000);
    check({tag, "_ready"}, req_ready, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, prev_a;
    op_t op;
    for (int i = 0; i < 256; i++) mem[i] = W'(16'h1000 + i * 16'h0101);
    mem[8] = 16'h00F7;
    bank_m = '0; rsp_m = '0; last_mar_m = '0; mar_valid_m = 1'b0;
    rst_n = 1'b0; programming_mode = 1'b0; req_valid = 1'b0;
    req_op = OP_MEM_RD; req_addr = '0; req_wdata = '0;
    tb_drv = 1'b1; tb_val = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); check("release_ready_0", req_ready, 1'b0);
    @(negedge clk); check("release_ready_1", req_ready, 1'b1);

    run_op(OP_MEM_WR, 16'h0005, 16'h00FA);
    run_op(OP_MEM_RD, 16'h0008, 16'h0000);
    run_op(OP_BANK_SET, 16'h0003, 16'h0000);
    run_op(OP_BANK_GET, 16'h0009, 16'h0000);
    run_op(OP_MEM_WR, 16'h0007, 16'h1111);
    run_op(OP_MEM_WR, 16'h0007, 16'h2222);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    run_op(OP_MEM_WR, 16'h0007, 16'h3333);
    run_op(OP_MEM_RD, 16'h0007, 16'h0000);

    // Abort during the first read cycle.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = OP_MEM_RD; req_addr = 16'h0021;
    @(negedge clk); check("abort_accept_ready", req_ready, 1'b1);
    @(posedge clk); #1 req_valid = 1'b0; tb_drv = 1'b0;
    last_mar_m = 16'h0021;
    @(negedge clk);
    check("abort_mar_strb", strb_obs, S_MAR);
    check("abort_mar_bus", data_bus, 16'h0021);
    @(posedge clk); #1 tb_drv = 1'b1; tb_val = 16'hBEEF; programming_mode = 1'b1;
    mar_valid_m = 1'b0;
    @(negedge clk); check("abort_rd_strb", strb_obs, S_RDM);
    @(posedge clk); #1 tb_val = '0; req_valid = 1'b1;
    @(negedge clk);
    check("abort_strb", strb_obs, S_NONE);
    check("abort_bus", data_bus, 16'h0000);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_rsp_data", rsp_data, rsp_m);
    check("abort_ready", req_ready, 1'b0);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Reset asserted during the write-data cycle.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = OP_MEM_WR; req_addr = 16'h0022; req_wdata = 16'h1234;
    @(negedge clk); check("rstwr_accept_ready", req_ready, 1'b1);
    @(posedge clk); #1 req_valid = 1'b0; tb_drv = 1'b0;
    @(negedge clk); check("rstwr_mar_strb", strb_obs, S_MAR);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstwr_wr_strb", strb_obs, S_WRM);
    check("rstwr_wr_bus", data_bus, 16'h1234);
    #2 rst_n = 1'b0;
    #1 tb_drv = 1'b1; tb_val = '0;
    #1 check_reset_outputs("rstwr");
    rsp_m = '0; mar_valid_m = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); check("rstwr_release_ready_0", req_ready, 1'b0);
    @(negedge clk); check("rstwr_release_ready_1", req_ready, 1'b1);

    prev_a = 16'h0005;
    for (int n = 0; n < 80; n++) begin
      op = op_t'($urandom_range(0, 3));
      a  = ($urandom_range(0, 1) == 0) ? prev_a : W'($urandom_range(1, 15));
      run_op(op, a, W'($urandom));
      prev_a = a;
      repeat ($urandom_range(0, 2)) idle_cycle($urandom_range(0, 9) == 0);
    end
    idle_cycle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
